gslcd_v1_0_fetch_sched: RTL and testbench

GSLCD_V1_0_FETCH_SCHED -- requirements
Module: gslcd_v1_0_fetch_sched

---
 rtl/gslcd_v1_0_fetch_sched.sv | 163 ++++++++++++++++
 tb/tb_gslcd_v1_0_fetch_sched.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gslcd_v1_0_fetch_sched.sv
`default_nettype none
// gslcd_v1_0_fetch_sched: framebuffer burst-read scheduler with pointer double-buffering
// and late-frame abort. Rev 1.0
module gslcd_v1_0_fetch_sched #(
  parameter int C_ADDR_WIDTH      = 32,
  parameter int C_BURST_BYTES     = 64,
  parameter int C_FRAME_BYTES     = 1152000,
  parameter int C_CNT_WIDTH       = 16,
  parameter int C_MAX_OUTSTANDING = 2,
  parameter int C_RST_CYCLES      = 5
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic                    EN,
  input  logic [C_ADDR_WIDTH-1:0] FRAME_PTR,
  input  logic                    PTR_VALID,
  input  logic                    FRAME_START,
  input  logic                    FIFO_ALMOST_FULL,
  output logic                    CMD_VALID,
  input  logic                    CMD_READY,
  output logic [C_ADDR_WIDTH-1:0] CMD_ADDR,
  output logic                    CMD_LAST,
  input  logic                    DONE,
  output logic                    FIFO_RST,
  output logic [C_ADDR_WIDTH-1:0] ACTIVE_PTR,
  output logic                    SWAP_ACK,
  output logic                    FRAME_LATE,
  input  logic                    CLR_LATE,
  output logic                    BUSY
);

  localparam int OW = $clog2(C_MAX_OUTSTANDING + 1);
  localparam int RW = (C_RST_CYCLES > 1) ? $clog2(C_RST_CYCLES) : 1;
  localparam logic [C_CNT_WIDTH-1:0] LAST_IDX = C_CNT_WIDTH'(C_FRAME_BYTES / C_BURST_BYTES - 1);
  localparam logic [OW-1:0]          MAX_OUT  = OW'(C_MAX_OUTSTANDING);
  localparam logic [RW-1:0]          RST_LOAD = RW'(C_RST_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FLUSH     = 3'd1,
    S_ISSUE     = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_ABORT     = 3'd4
  } state_t;

  state_t                  state_q;
  logic [RW-1:0]           rst_cnt_q;
  logic [C_CNT_WIDTH-1:0]  idx_q;
  logic [OW-1:0]           outst_q;
  logic [C_ADDR_WIDTH-1:0] pend_ptr_q;
  logic                    pend_vld_q;
  logic [C_ADDR_WIDTH-1:0] active_q;
  logic                    cmd_valid_q;
  logic [C_ADDR_WIDTH-1:0] cmd_addr_q;
  logic                    cmd_last_q;
  logic                    fifo_rst_q;
  logic                    swap_ack_q;
  logic                    late_q;

  logic                    fs;
  logic                    hs;
  logic                    dn;
  logic                    swap;
  logic                    can_issue;
  logic [C_ADDR_WIDTH-1:0] burst_addr;

  assign fs   = FRAME_START & EN;
  assign hs   = cmd_valid_q & CMD_READY;
  assign dn   = DONE & (outst_q != '0);
  assign swap = fs & pend_vld_q;
  // A frame start suppresses any new request in the same cycle so an abort never races a fresh burst.
  assign can_issue  = (state_q == S_ISSUE) & ~cmd_valid_q & ~FIFO_ALMOST_FULL
                    & (outst_q < MAX_OUT) & ~fs;
  assign burst_addr = active_q + C_ADDR_WIDTH'(idx_q) * C_ADDR_WIDTH'(C_BURST_BYTES);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q     <= S_IDLE;
      rst_cnt_q   <= '0;
      idx_q       <= '0;
      outst_q     <= '0;
      pend_ptr_q  <= '0;
      pend_vld_q  <= 1'b0;
      active_q    <= '0;
      cmd_valid_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_last_q  <= 1'b0;
      fifo_rst_q  <= 1'b0;
      swap_ack_q  <= 1'b0;
      late_q      <= 1'b0;
    end else begin
      swap_ack_q <= swap;
      if (swap) active_q <= pend_ptr_q;
      // A pointer written alongside the swapping frame start stays pending for the next frame.
      if (PTR_VALID) begin
        pend_ptr_q <= FRAME_PTR;
        pend_vld_q <= 1'b1;
      end else if (swap) begin
        pend_vld_q <= 1'b0;
      end

      if (fs && state_q != S_IDLE) late_q <= 1'b1;
      else if (CLR_LATE)           late_q <= 1'b0;

      if (hs && !dn)      outst_q <= outst_q + OW'(1);
      else if (!hs && dn) outst_q <= outst_q - OW'(1);

      if (hs) begin
        cmd_valid_q <= 1'b0;
        cmd_last_q  <= 1'b0;
        idx_q       <= idx_q + C_CNT_WIDTH'(1);
      end else if (can_issue) begin
        cmd_valid_q <= 1'b1;
        cmd_addr_q  <= burst_addr;
        cmd_last_q  <= (idx_q == LAST_IDX);
      end

      case (state_q)
        S_IDLE: if (fs) begin
          state_q    <= S_FLUSH;
          fifo_rst_q <= 1'b1;
          rst_cnt_q  <= RST_LOAD;
        end
        S_FLUSH: begin
          if (fs) begin
            rst_cnt_q <= RST_LOAD;
          end else if (rst_cnt_q == '0) begin
            state_q    <= S_ISSUE;
            fifo_rst_q <= 1'b0;
            idx_q      <= '0;
          end else begin
            rst_cnt_q <= rst_cnt_q - RW'(1);
          end
        end
        S_ISSUE: begin
          if (fs)                    state_q <= S_ABORT;
          else if (hs && cmd_last_q) state_q <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (fs)                   state_q <= S_ABORT;
          else if (outst_q == '0)   state_q <= S_IDLE;
        end
        S_ABORT: if (!fs && !cmd_valid_q && outst_q == '0) begin
          state_q    <= S_FLUSH;
          fifo_rst_q <= 1'b1;
          rst_cnt_q  <= RST_LOAD;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign CMD_VALID  = cmd_valid_q;
  assign CMD_ADDR   = cmd_addr_q;
  assign CMD_LAST   = cmd_last_q;
  assign FIFO_RST   = fifo_rst_q;
  assign ACTIVE_PTR = active_q;
  assign SWAP_ACK   = swap_ack_q;
  assign FRAME_LATE = late_q;
  assign BUSY       = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_gslcd_v1_0_fetch_sched.sv
`default_nettype none
// tb_gslcd_v1_0_fetch_sched: directed stimulus against a frame-level reference model
// (4 bursts of 64 B per frame, at most 2 outstanding, 5-cycle FIFO reset).
module tb_gslcd_v1_0_fetch_sched;

  localparam int M_IDLE = 0, M_FLUSH = 1, M_RUN = 2, M_ABORT = 3;

  logic        ACLK = 1'b0, ARESETN = 1'b0, EN = 1'b0, PTR_VALID = 1'b0, FRAME_START = 1'b0;
  logic        FIFO_ALMOST_FULL = 1'b0, CMD_READY = 1'b0, DONE = 1'b0, CLR_LATE = 1'b0;
  logic [31:0] FRAME_PTR = '0;
  logic        CMD_VALID, CMD_LAST, FIFO_RST, SWAP_ACK, FRAME_LATE, BUSY;
  logic [31:0] CMD_ADDR, ACTIVE_PTR;

  gslcd_v1_0_fetch_sched #(
    .C_ADDR_WIDTH(32), .C_BURST_BYTES(64), .C_FRAME_BYTES(256),
    .C_CNT_WIDTH(16), .C_MAX_OUTSTANDING(2), .C_RST_CYCLES(5)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .EN(EN), .FRAME_PTR(FRAME_PTR), .PTR_VALID(PTR_VALID),
    .FRAME_START(FRAME_START), .FIFO_ALMOST_FULL(FIFO_ALMOST_FULL), .CMD_VALID(CMD_VALID),
    .CMD_READY(CMD_READY), .CMD_ADDR(CMD_ADDR), .CMD_LAST(CMD_LAST), .DONE(DONE),
    .FIFO_RST(FIFO_RST), .ACTIVE_PTR(ACTIVE_PTR), .SWAP_ACK(SWAP_ACK), .FRAME_LATE(FRAME_LATE),
    .CLR_LATE(CLR_LATE), .BUSY(BUSY)
  );

  always #5 ACLK = ~ACLK;

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame phase, burst count, outstanding count, pointer registers.
  int          m_phase = M_IDLE, m_cnt = 0, m_idx = 0, m_outst = 0, c_ph;
  logic [31:0] m_act = '0, m_pend = '0, m_base = '0, p_addr = '0;
  logic        m_pv = 0, m_swap = 0, m_late = 0;
  logic        p_valid = 0, p_held = 0, p_last = 0, p_may = 0;
  logic        c_fs, c_hs, c_dn;
  logic [31:0] hs_addr[$];
  logic        hs_last[$];
  int          rst_seen = 0, swap_seen = 0;

  always @(negedge ACLK) begin
    if (!ARESETN) begin
      m_phase = M_IDLE; m_cnt = 0; m_idx = 0; m_outst = 0;
      m_act = '0; m_pv = 0; m_swap = 0; m_late = 0;
      p_valid = 0; p_held = 0; p_may = 0;
    end
    chk("BUSY", BUSY, m_phase != M_IDLE);
    chk("FIFO_RST", FIFO_RST, m_phase == M_FLUSH);
    chk("SWAP_ACK", SWAP_ACK, m_swap);
    chk("FRAME_LATE", FRAME_LATE, m_late);
    chk("ACTIVE_PTR", ACTIVE_PTR, m_act);
    if (FIFO_RST) rst_seen++;
    if (SWAP_ACK) swap_seen++;
    if (!ARESETN) begin
      chk("rst_CMD_VALID", CMD_VALID, 0);
      chk("rst_CMD_ADDR", CMD_ADDR, 0);
      chk("rst_CMD_LAST", CMD_LAST, 0);
    end else begin
      if (m_phase == M_IDLE || m_phase == M_FLUSH) chk("CMD_VALID_quiet", CMD_VALID, 0);
      if (p_held) begin
        chk("hold_valid", CMD_VALID, 1);
        chk("hold_addr", CMD_ADDR, p_addr);
        chk("hold_last", CMD_LAST, p_last);
      end
      if (CMD_VALID && !p_valid) chk("issue_allowed", p_may, 1);

      c_fs = FRAME_START && EN;
      c_hs = CMD_VALID && CMD_READY;
      c_dn = DONE && (m_outst > 0);
      c_ph = m_phase;
      p_may   = (m_phase == M_RUN) && (m_idx < 4) && !FIFO_ALMOST_FULL && (m_outst < 2)
                && !c_fs && !CMD_VALID;
      p_valid = CMD_VALID;
      p_held  = CMD_VALID && !CMD_READY;
      p_addr  = CMD_ADDR;
      p_last  = CMD_LAST;
      if (c_hs) begin
        chk("hs_phase", (m_phase == M_RUN || m_phase == M_ABORT), 1);
        chk("hs_addr", CMD_ADDR, m_base + m_idx * 64);
        chk("hs_last", CMD_LAST, m_idx == 3);
        hs_addr.push_back(CMD_ADDR);
        hs_last.push_back(CMD_LAST);
      end
      case (c_ph)
        M_IDLE:  if (c_fs) begin m_phase = M_FLUSH; m_cnt = 5; end
        M_FLUSH: if (c_fs) m_cnt = 5;
                 else begin
                   m_cnt--;
                   if (m_cnt == 0) begin m_phase = M_RUN; m_idx = 0; m_base = m_act; end
                 end
        M_RUN:   if (c_fs) m_phase = M_ABORT;
                 else if (m_idx == 4 && m_outst == 0) m_phase = M_IDLE;
        default: if (!c_fs && !CMD_VALID && m_outst == 0) begin m_phase = M_FLUSH; m_cnt = 5; end
      endcase
      if (c_hs) m_idx++;
      m_swap = c_fs && m_pv;
      if (m_swap) m_act = m_pend;
      if (PTR_VALID) begin m_pend = FRAME_PTR; m_pv = 1; end
      else if (m_swap) m_pv = 0;
      if (c_fs && c_ph != M_IDLE) m_late = 1;
      else if (CLR_LATE) m_late = 0;
      m_outst = m_outst + (c_hs ? 1 : 0) - (c_dn ? 1 : 0);
    end
  end

  // DONE responder: automatic mode answers each accept 3 cycles later; manual mode on request.
  int   dq[$];
  logic auto_done = 0;
  int   man_req = 0, man_ack = 0;
  always @(posedge ACLK) begin : resp
    logic hs_s;
    hs_s = CMD_VALID && CMD_READY && ARESETN;
    #1;
    DONE = 0;
    foreach (dq[i]) dq[i]--;
    if (dq.size() > 0 && dq[0] <= 0) begin DONE = 1; void'(dq.pop_front()); end
    if (hs_s && auto_done) dq.push_back(3);
    if (man_req != man_ack) begin DONE = 1; man_ack++; end
    if (!ARESETN) begin dq.delete(); DONE = 0; end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge ACLK); #1; end
  endtask
  task automatic fs_pulse();
    FRAME_START = 1; step(1); FRAME_START = 0;
  endtask
  task automatic ptr_write(input logic [31:0] p);
    FRAME_PTR = p; PTR_VALID = 1; step(1); PTR_VALID = 0;
  endtask
  task automatic wait_idle(input string name);
    int k = 0;
    while (BUSY && k < 300) begin step(1); k++; end
    chk({name, "_idle"}, BUSY, 0);
  endtask
  task automatic wait_valid(input string name);
    int k = 0;
    while (!CMD_VALID && k < 50) begin step(1); k++; end
    chk(name, CMD_VALID, 1);
  endtask
  task automatic wait_hs(input int n, input string name);
    int k = 0;
    while (hs_addr.size() < n && k < 100) begin step(1); k++; end
    chk(name, hs_addr.size(), n);
  endtask

  logic [31:0] exp_nom[4] = '{32'h1000_0000, 32'h1000_0040, 32'h1000_0080, 32'h1000_00C0};
  int h0, h1, r0, s0, nv;

  initial begin
    step(3);
    chk("reset_valid", CMD_VALID, 0);
    chk("reset_busy", BUSY, 0);
    chk("reset_active", ACTIVE_PTR, 0);
    ARESETN = 1; EN = 1; CMD_READY = 1; auto_done = 1;
    step(2);

    // nominal frame
    ptr_write(32'h1000_0000);
    h0 = hs_addr.size(); r0 = rst_seen; s0 = swap_seen;
    fs_pulse();
    wait_idle("nominal");
    chk("nom_count", hs_addr.size() - h0, 4);
    for (int i = 0; i < 4; i++) begin
      chk("nom_addr", hs_addr[h0 + i], exp_nom[i]);
      chk("nom_last", hs_last[h0 + i], i == 3);
    end
    chk("nom_rst_cycles", rst_seen - r0, 5);
    chk("nom_swaps", swap_seen - s0, 1);
    chk("nom_active", ACTIVE_PTR, 32'h1000_0000);

    // backpressure on CMD_READY and FIFO_ALMOST_FULL
    CMD_READY = 0; h0 = hs_addr.size();
    fs_pulse();
    wait_valid("bp_valid");
    step(1); FIFO_ALMOST_FULL = 1; step(9);
    chk("bp_held_valid", CMD_VALID, 1);
    chk("bp_held_addr", CMD_ADDR, 32'h1000_0000);
    CMD_READY = 1; step(1);
    nv = 0;
    repeat (8) begin step(1); if (CMD_VALID) nv++; end
    chk("bp_no_new", nv, 0);
    chk("bp_accepts", hs_addr.size() - h0, 1);
    FIFO_ALMOST_FULL = 0;
    wait_idle("bp");
    chk("bp_count", hs_addr.size() - h0, 4);
    chk("bp_last_addr", hs_addr[hs_addr.size() - 1], 32'h1000_00C0);

    // outstanding limit, with EN dropped mid-frame
    auto_done = 0; h0 = hs_addr.size();
    fs_pulse(); EN = 0;
    step(30);
    chk("ol_accepts", hs_addr.size() - h0, 2);
    chk("ol_valid", CMD_VALID, 0);
    man_req++; step(6);
    chk("ol_after_done", hs_addr.size() - h0, 3);
    repeat (3) begin man_req++; step(4); end
    wait_idle("ol");
    chk("ol_count", hs_addr.size() - h0, 4);
    EN = 1;

    // late frame after two accepts
    h0 = hs_addr.size();
    fs_pulse();
    ptr_write(32'h3000_0000);
    wait_hs(h0 + 2, "late_two");
    fs_pulse();
    chk("late_flag", FRAME_LATE, 1);
    chk("late_active", ACTIVE_PTR, 32'h3000_0000);
    step(5);
    chk("late_abort_busy", BUSY, 1);
    chk("late_no_flush", FIFO_RST, 0);
    chk("late_no_cmd", CMD_VALID, 0);
    h1 = hs_addr.size();
    man_req++; step(3); man_req++;
    nv = 0;
    while (!FIFO_RST && nv < 20) begin step(1); nv++; end
    chk("late_flush", FIFO_RST, 1);
    auto_done = 1;
    wait_idle("late");
    chk("late_restart_n", hs_addr.size() - h1, 4);
    chk("late_restart_addr0", hs_addr[h1], 32'h3000_0000);
    CLR_LATE = 1; step(1); CLR_LATE = 0;
    chk("late_cleared", FRAME_LATE, 0);

    // pointer write coincident with frame start
    ptr_write(32'h1000_0000);
    h0 = hs_addr.size();
    FRAME_PTR = 32'h2000_0000; PTR_VALID = 1; FRAME_START = 1;
    step(1);
    PTR_VALID = 0; FRAME_START = 0;
    chk("coin_active", ACTIVE_PTR, 32'h1000_0000);
    wait_idle("coin1");
    chk("coin_addr", hs_addr[h0], 32'h1000_0000);
    h0 = hs_addr.size();
    fs_pulse();
    chk("coin_next_active", ACTIVE_PTR, 32'h2000_0000);
    wait_idle("coin2");
    chk("coin_next_addr", hs_addr[h0], 32'h2000_0000);

    // frame start with EN low is ignored
    ptr_write(32'h4000_0000);
    EN = 0; fs_pulse(); step(2);
    chk("en0_busy", BUSY, 0);
    chk("en0_active", ACTIVE_PTR, 32'h2000_0000);
    EN = 1;

    // reset in the middle of a held request
    CMD_READY = 0;
    fs_pulse();
    wait_valid("rst_valid");
    ARESETN = 0; #1;
    chk("rst_mid_valid", CMD_VALID, 0);
    chk("rst_mid_addr", CMD_ADDR, 0);
    chk("rst_mid_active", ACTIVE_PTR, 0);
    chk("rst_mid_busy", BUSY, 0);
    step(2);
    ARESETN = 1; CMD_READY = 1;
    nv = 0;
    repeat (10) begin step(1); if (CMD_VALID) nv++; end
    chk("post_rst_quiet", nv, 0);
    h0 = hs_addr.size();
    fs_pulse();
    wait_idle("post_rst");
    chk("post_rst_count", hs_addr.size() - h0, 4);
    chk("post_rst_addr0", hs_addr[h0], 32'h0000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
